// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel controller: display modes,
// fixed LED patterns and the small helpers used by the LED sequencer.
package panel_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [5:0] LEDS_ALL   = 6'h3F;
    localparam logic [5:0] LEDS_NONE  = 6'h00;
    localparam logic [5:0] CHASE_SEED = 6'b000001;

    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_OFF:   nxt = MODE_SOLID;
            MODE_SOLID: nxt = MODE_CHASE;
            MODE_CHASE: nxt = MODE_BLINK;
            default:    nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

    // Left moves the lit bit from bit0 towards bit5; right is the reverse.
    function automatic logic [5:0] rotate_leds(input logic [5:0] cur, input logic right);
        return right ? {cur[0], cur[5:1]} : {cur[4:0], cur[5]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchroniser, tick-based debounce and a
// single-cycle pulse on each accepted release-to-press transition.
module btn_debounce #(
    parameter int DEB_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          level;

    // Pins idle high, so the synchroniser resets to the released level.
    assign level = ~sync_q[1];

    always_comb begin
        sync_d   = {sync_q[0], btn_n_i};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (level == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CW'(DEB_TICKS - 1)) begin
                cnt_d    = '0;
                stable_d = level;
                press_d  = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: timebase, two debounced buttons, 4-mode LED
// display state machine and a fixed-length square-wave beeper.
module panel_ctrl
    import panel_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 20,
    parameter int STEP_TICKS = 250,
    parameter int BEEP_HALF  = 12500,
    parameter int BEEP_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] buttons_i,
    output logic [5:0] leds_o,
    output logic       beep_o,
    output logic [1:0] mode_o,
    output logic [1:0] press_o
);

    localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int HW = (BEEP_HALF > 1)  ? $clog2(BEEP_HALF)  : 1;
    localparam int DW = $clog2(BEEP_TICKS + 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [1:0]    press;

    mode_e         mode_q, mode_d;
    logic          dir_q, dir_d;
    logic [5:0]    leds_q, leds_d;
    logic [SW-1:0] step_q, step_d;

    logic [DW-1:0] dur_q, dur_d;
    logic [HW-1:0] half_q, half_d;
    logic          beep_q, beep_d;

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_btn (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .btn_n_i (buttons_i[i]),
            .press_o (press[i])
        );
    end

    // A mode change reloads the entry pattern and restarts the step period;
    // direction is tracked in every mode so a toggle made early is kept.
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q ^ press[1];
        leds_d = leds_q;
        step_d = step_q;
        if (press[0]) begin
            mode_d = next_mode(mode_q);
            step_d = '0;
            case (mode_d)
                MODE_SOLID: leds_d = LEDS_ALL;
                MODE_CHASE: leds_d = CHASE_SEED;
                MODE_BLINK: leds_d = LEDS_ALL;
                default:    leds_d = LEDS_NONE;
            endcase
        end else if (tick) begin
            if (step_q == SW'(STEP_TICKS - 1)) begin
                step_d = '0;
                case (mode_q)
                    MODE_CHASE: leds_d = rotate_leds(leds_q, dir_q);
                    MODE_BLINK: leds_d = ~leds_q;
                    default:    leds_d = leds_q;
                endcase
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    // Any press restarts both the duration and the tone phase.
    always_comb begin
        dur_d  = dur_q;
        half_d = half_q;
        beep_d = beep_q;
        if (|press) begin
            dur_d  = DW'(BEEP_TICKS);
            half_d = '0;
            beep_d = 1'b1;
        end else if (dur_q != '0) begin
            if (tick) begin
                dur_d = dur_q - 1'b1;
            end
            if (dur_d == '0) begin
                half_d = '0;
                beep_d = 1'b0;
            end else if (half_q == HW'(BEEP_HALF - 1)) begin
                half_d = '0;
                beep_d = ~beep_q;
            end else begin
                half_d = half_q + 1'b1;
            end
        end else begin
            half_d = '0;
            beep_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            mode_q     <= MODE_OFF;
            dir_q      <= 1'b0;
            leds_q     <= LEDS_NONE;
            step_q     <= '0;
            dur_q      <= '0;
            half_q     <= '0;
            beep_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            leds_q     <= leds_d;
            step_q     <= step_d;
            dur_q      <= dur_d;
            half_q     <= half_d;
            beep_q     <= beep_d;
        end
    end

    assign leds_o  = leds_q;
    assign beep_o  = beep_q;
    assign mode_o  = mode_q;
    assign press_o = press;

endmodule
